// File: rtl/rv_pkg.sv
// ============================================================================
//  Module   : rv_pkg
//  Brief    : Shared RV32I pipeline types and constants.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
//  Module   : fetch_queue
//  Brief    : In-order circular buffer of fetch entries (alloc/fill/pop/flush).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_alloc,
  input  logic [31:0]        i_alloc_pc,
  input  logic               i_fill,
  input  logic [31:0]        i_fill_instr,
  input  logic               i_pop,
  input  logic               i_flush,
  output fetch_entry_t       o_head,
  output logic [CW-1:0]      o_count,
  output logic [CW-1:0]      o_unfilled
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW-1:0] r_fill;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_unfilled;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '{pc: 32'h0, instr: NOP, filled: 1'b0};
      end
    end else if (i_flush) begin
      // Flush is only issued while the head is filled, so it is the sole survivor.
      for (int i = 0; i < DEPTH; i++) begin
        if (i_pop || (AW'(i) != r_head)) begin
          r_mem[i].filled <= 1'b0;
        end
      end
      r_unfilled <= '0;
      if (i_pop) begin
        r_head  <= r_head + AW'(1);
        r_tail  <= r_head + AW'(1);
        r_fill  <= r_head + AW'(1);
        r_count <= '0;
      end else begin
        r_tail  <= r_head + AW'(1);
        r_fill  <= r_head + AW'(1);
        r_count <= CW'(1);
      end
    end else begin
      if (i_alloc) begin
        r_mem[r_tail] <= '{pc: i_alloc_pc, instr: NOP, filled: 1'b0};
        r_tail        <= r_tail + AW'(1);
      end
      if (i_fill) begin
        r_mem[r_fill].instr  <= i_fill_instr;
        r_mem[r_fill].filled <= 1'b1;
        r_fill               <= r_fill + AW'(1);
      end
      if (i_pop) begin
        r_mem[r_head].filled <= 1'b0;
        r_head               <= r_head + AW'(1);
      end
      r_count    <= r_count + CW'(i_alloc) - CW'(i_pop);
      r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
    end
  end

  assign o_head     = r_mem[r_head];
  assign o_count    = r_count;
  assign o_unfilled = r_unfilled;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module   : fetch_stage
//  Brief    : RV32I instruction fetch: PC, request issue, wrong-path drop.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcsel,
  input  logic [31:0] target,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [31:0]   r_fpc;
  logic [31:0]   r_pc_hold;
  logic [CW-1:0] r_drop;

  fetch_entry_t  w_head;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_unfilled;
  logic [OW-1:0] w_occ;
  logic          w_valid;
  logic          w_consume;
  logic          w_redirect;
  logic          w_accept;
  logic          w_dropping;
  logic          w_keep;
  logic          w_fill;

  assign w_valid    = w_head.filled;
  assign w_consume  = w_valid & ~stall;
  assign w_redirect = w_consume & pcsel;
  assign w_occ      = OW'(w_count) + OW'(r_drop);

  assign imem_req_valid = rst & ~w_redirect & (w_occ < OW'(DEPTH));
  assign imem_req_addr  = r_fpc;
  assign w_accept       = imem_req_valid & imem_req_ready;

  // A response landing on the redirect cycle belongs to a flushed entry.
  assign w_dropping = (r_drop != '0);
  assign w_keep     = imem_rsp_valid & ~w_dropping;
  assign w_fill     = w_keep & ~w_redirect;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_alloc      (w_accept),
    .i_alloc_pc   (r_fpc),
    .i_fill       (w_fill),
    .i_fill_instr (imem_rsp_data),
    .i_pop        (w_consume),
    .i_flush      (w_redirect),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_unfilled   (w_unfilled)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fpc     <= RESET_PC;
      r_drop    <= '0;
      r_pc_hold <= RESET_PC;
    end else begin
      if (w_redirect) begin
        r_fpc <= target;
      end else if (w_accept) begin
        r_fpc <= r_fpc + 32'd4;
      end
      if (w_redirect) begin
        r_drop <= w_unfilled - CW'(w_keep);
      end else if (imem_rsp_valid && w_dropping) begin
        r_drop <= r_drop - CW'(1);
      end
      if (w_valid) begin
        r_pc_hold <= w_head.pc;
      end
    end
  end

  assign valid = w_valid;
  assign instr = w_valid ? w_head.instr : NOP;
  assign pc    = w_valid ? w_head.pc : r_pc_hold;
  assign pc4   = pc + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Randomized scoreboard bench for fetch_stage with a memory model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;
  import rv_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pcsel = 1'b0;
  logic [31:0] target = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pcsel          (pcsel),
    .target         (target),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .valid          (valid),
    .instr          (instr),
    .pc             (pc),
    .pc4            (pc4)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks   = 0;
  int          failures = 0;
  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_pc = RPC;
  bit          mon_en = 1'b0;
  int          idle = 0;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rand_drive = 1'b0;
  logic        s_acc;
  logic        s_rsp;
  logic [31:0] s_addr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every presented instruction with the model stream.
  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_en) begin
      if (valid) begin
        if (!stall) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got pc %h expected no instruction", pc);
          end else begin
            e = exp_q.pop_front();
            chk("pc", pc, e);
            chk("instr", instr, memword(e));
            chk("pc4", pc4, e + 32'd4);
            exp_q.push_back(pcsel ? target : e + 32'd4);
          end
          idle = 0;
        end
        last_pc = pc;
      end else begin
        chk("instr_nop", instr, NOP);
        chk("pc_hold", pc, last_pc);
        idle++;
        if (idle > 200) begin
          checks++;
          failures++;
          $display("FAIL watchdog: got no instruction for %0d cycles expected progress", idle);
          idle = 0;
        end
      end
    end
  end

  task automatic drive_rsp();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic rand_target();
    logic [31:0] t;
    t = $urandom;
    t[1:0] = 2'b00;
    target = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : t;
  endtask

  // One clock: sample handshakes mid-cycle, then advance memory and drive inputs.
  task automatic cycle();
    @(negedge clk);
    s_acc  = imem_req_valid & imem_req_ready;
    s_addr = imem_req_addr;
    s_rsp  = imem_rsp_valid;
    @(posedge clk);
    #1;
    if (s_rsp) void'(pend.pop_front());
    if (s_acc) pend.push_back('{addr: s_addr, due: cyc + $urandom_range(lat_max, lat_min)});
    cyc++;
    drive_rsp();
    if (rand_drive) begin
      stall          = ($urandom_range(99, 0) < 30);
      pcsel          = ($urandom_range(99, 0) < 10);
      imem_req_ready = ($urandom_range(99, 0) < 70);
      rand_target();
    end
  endtask

  task automatic restart();
    exp_q.delete();
    exp_q.push_back(RPC);
    last_pc = RPC;
    rst     = 1'b1;
    mon_en  = 1'b1;
    #1;
    chk("release_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("release_req_addr", imem_req_addr, RPC);
  endtask

  initial begin
    logic [31:0] spc;
    logic        sv;
    imem_req_ready = 1'b1;
    repeat (3) cycle();
    #1;
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, RPC);
    chk("rst_pc4", pc4, RPC + 32'd4);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);

    restart();
    cycle();
    #1;
    chk("c1_valid", {31'h0, valid}, 32'h0);
    chk("c1_req_addr", imem_req_addr, RPC + 32'd4);
    cycle();
    #1;
    chk("c2_valid", {31'h0, valid}, 32'h1);
    chk("c2_pc", pc, RPC);
    // Redirect on the very cycle the second word's response arrives.
    pcsel  = 1'b1;
    target = 32'h0000_0100;
    cycle();
    pcsel = 1'b0;
    #1;
    chk("redir_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("redir_req_addr", imem_req_addr, 32'h0000_0100);
    repeat (8) cycle();

    sv    = valid;
    spc   = pc;
    stall = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      if (k >= 4) chk("stall_full_req_valid", {31'h0, imem_req_valid}, 32'h0);
      if (sv) chk("stall_pc_held", pc, spc);
      cycle();
    end
    stall = 1'b0;
    repeat (10) cycle();

    lat_min = 3;
    lat_max = 3;
    repeat (10) cycle();
    for (int k = 0; k < 20 && !valid; k++) cycle();
    pcsel  = 1'b1;
    target = 32'h0000_0200;
    cycle();
    // Redirects offered while nothing is presented must be ignored.
    target = 32'h0000_0400;
    for (int k = 0; k < 20; k++) begin
      pcsel = ~valid;
      cycle();
    end
    pcsel  = 1'b1;
    stall  = 1'b1;
    target = 32'h0000_0300;
    repeat (3) cycle();
    pcsel = 1'b0;
    stall = 1'b0;
    repeat (15) cycle();

    lat_min    = 1;
    lat_max    = 4;
    rand_drive = 1'b1;
    for (int r = 0; r < 3; r++) begin
      repeat (1500) cycle();
      rst    = 1'b0;
      mon_en = 1'b0;
      cycle();
      #1;
      chk("midrst_valid", {31'h0, valid}, 32'h0);
      chk("midrst_instr", instr, NOP);
      chk("midrst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      for (int k = 0; k < 20 && pend.size() > 0; k++) cycle();
      pend.delete();
      imem_rsp_valid = 1'b0;
      restart();
    end
    repeat (500) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
